// File: rtl/gowin_prim_pkg.sv
// Shared constants and constant functions for the Gowin-style primitive models.
package gowin_prim_pkg;

    localparam int EDGE_POS = 0;
    localparam int EDGE_NEG = 1;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/dff_delay_stage.sv
// Single clock-enabled register stage of the delay line with selectable active edge.
module dff_delay_stage
    import gowin_prim_pkg::*;
#(
    parameter int   WIDTH = 1,
    parameter int   EDGE  = EDGE_POS,
    parameter logic INIT  = 1'b0
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             CE,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    localparam logic [WIDTH-1:0] INIT_VEC = {WIDTH{INIT}};

    logic             clk_s;
    // Stored relative to INIT so that an all-zero power-up state reads back as INIT.
    logic [WIDTH-1:0] q_x_r;

    assign clk_s = (EDGE == EDGE_NEG) ? ~CLK : CLK;

    // Stage register: async reset to INIT, load D when enabled.
    always_ff @(posedge clk_s or negedge RESETN) begin
        if (!RESETN) begin
            q_x_r <= {WIDTH{1'b0}};
        end else if (CE) begin
            q_x_r <= D ^ INIT_VEC;
        end else begin
            q_x_r <= q_x_r;
        end
    end

    assign Q = q_x_r ^ INIT_VEC;

endmodule

// File: rtl/dff_delay_line.sv
// Parameterised tapped shift register with fill tracking.
// Optional macro DFF_DELAY_LINE_OREG_EN registers the tap output Q.
module dff_delay_line
    import gowin_prim_pkg::*;
#(
    parameter int   WIDTH  = 1,
    parameter int   DEPTH  = 16,
    parameter int   EDGE   = EDGE_POS,
    parameter logic INIT   = 1'b0,
    localparam int  ADDR_W = clog2(DEPTH),
    localparam int  CNT_W  = clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              CE,
    input  logic [WIDTH-1:0]  D,
    input  logic [ADDR_W-1:0] ADDR,
    output logic [WIDTH-1:0]  Q,
    output logic [WIDTH-1:0]  QL,
    output logic              FULL
);

    localparam logic [WIDTH-1:0] INIT_VEC  = {WIDTH{INIT}};
    localparam logic [CNT_W-1:0] FILL_MAX  = CNT_W'(DEPTH);
    localparam logic [31:0]      DEPTH_U32 = 32'(DEPTH);

    logic             clk_s;
    logic [WIDTH-1:0] stage_s [DEPTH];
    logic [WIDTH-1:0] tap_s;
    logic [31:0]      addr_ext_s;
    logic [CNT_W-1:0] fill_cnt_r;
    logic             full_r;

    assign clk_s = (EDGE == EDGE_NEG) ? ~CLK : CLK;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_first
            dff_delay_stage #(
                .WIDTH (WIDTH),
                .EDGE  (EDGE),
                .INIT  (INIT)
            ) u_stage (
                .CLK    (CLK),
                .RESETN (RESETN),
                .CE     (CE),
                .D      (D),
                .Q      (stage_s[g])
            );
        end else begin : g_rest
            dff_delay_stage #(
                .WIDTH (WIDTH),
                .EDGE  (EDGE),
                .INIT  (INIT)
            ) u_stage (
                .CLK    (CLK),
                .RESETN (RESETN),
                .CE     (CE),
                .D      (stage_s[g-1]),
                .Q      (stage_s[g])
            );
        end
    end

    // Fill counter saturates at DEPTH; FULL is registered alongside it.
    always_ff @(posedge clk_s or negedge RESETN) begin
        if (!RESETN) begin
            fill_cnt_r <= {CNT_W{1'b0}};
            full_r     <= 1'b0;
        end else if (CE && (fill_cnt_r != FILL_MAX)) begin
            fill_cnt_r <= fill_cnt_r + CNT_W'(1);
            full_r     <= (fill_cnt_r == (FILL_MAX - CNT_W'(1)));
        end else begin
            fill_cnt_r <= fill_cnt_r;
            full_r     <= full_r;
        end
    end

    assign addr_ext_s = 32'(ADDR);

    // Tap mux: out-of-range addresses (non power-of-two DEPTH) select the last stage.
    always_comb begin
        tap_s = stage_s[DEPTH-1];
        if (addr_ext_s < DEPTH_U32) begin
            tap_s = stage_s[ADDR];
        end else begin
            tap_s = stage_s[DEPTH-1];
        end
    end

`ifdef DFF_DELAY_LINE_OREG_EN
    logic [WIDTH-1:0] q_x_r;

    // Output register samples the tap on every active edge, independent of CE.
    always_ff @(posedge clk_s or negedge RESETN) begin
        if (!RESETN) begin
            q_x_r <= {WIDTH{1'b0}};
        end else begin
            q_x_r <= tap_s ^ INIT_VEC;
        end
    end

    assign Q = q_x_r ^ INIT_VEC;
`else
    assign Q = tap_s;
`endif

    assign QL   = stage_s[DEPTH-1];
    assign FULL = full_r;

endmodule
